motor_drive_sequencer: RTL
==========================

// Module: motor_drive_sequencer
// PURPOSE
//  Sequences the brushless commutation stage: generates drv_mag and brake_n from a
//  requested torque magnitude with slew-limited soft start/stop.
//  Forces braking on request and measures the commutation period from the hall sensors.
//  Detects stall and invalid hall codes, latching a fault that holds the motor braked.
//  Sits between the torque/PID logic (target_mag, en, brake_req) and the commutation block.
// PARAMETERS
//  RAMP_DIV      1024        clk cycles per ramp tick (>=2)
//  RAMP_STEP     4           drv_mag change per ramp tick (LSBs of 12-bit magnitude)
//  STALL_CYC     24'd2000000 cycles without hall transition => stall (must be < 2^24-1)
//  STALL_MIN_MAG 12'h100     stall check armed only when drv_mag >= this value
//  BRAKE_HOLD    16'd50000   minimum cycles spent in BRAKE
//  BAD_HALL_CYC  16          consecutive synced cycles of hall code 000/111 => fault
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous active-high reset
//  en           in   1   run request; deassert => ramp down to 0 then IDLE
//  brake_req    in   1   brake request (level)
//  clr_fault    in   1   fault clear; honoured only while en==0
//  target_mag   in   12  requested drive magnitude
//  hallGrn      in   1   hall sensor, asynchronous
//  hallYlw      in   1   hall sensor, asynchronous
//  hallBlu      in   1   hall sensor, asynchronous
//  drv_mag      out  12  slewed magnitude to commutation block (registered)
//  brake_n      out  1   active-low brake to commutation block (registered)
//  running      out  1   high in RUN state
//  fault        out  1   high in FAULT state
//  comm_period  out  24  cycles between last two valid hall transitions; all-ones = stopped/unknown
// BEHAVIOUR
//  Reset values:
//  - Outputs: drv_mag=0, brake_n=1, running=0, fault=0, comm_period=24'hFFFFFF.
//  - Internal: state=IDLE, all counters 0.
//  - Reset asserted mid-operation returns everything to these values on the next edge.
//  Hall input path:
//  - Double-flopped into hall_s[2:0]; hall_p is hall_s delayed one cycle.
//  - Valid transition: hall_s != hall_p and hall_s not in {000,111}.
//  Commutation period counter (pcnt, 24 bit):
//  - Increments every cycle and saturates at all-ones.
//  - On a valid transition: comm_period <= pcnt, then pcnt <= 1.
//  - In IDLE/BRAKE/FAULT: pcnt saturates naturally; comm_period is forced to all-ones on entry to IDLE.
//  Bad-hall counter:
//  - Counts consecutive cycles with hall_s in {000,111}; clears otherwise.
//  - Reaching BAD_HALL_CYC in RUN => FAULT.
//  Ramp tick:
//  - Free-running counter 0..RAMP_DIV-1; tick pulses one cycle at terminal count.
//  - The counter is cleared whenever state is not RUN.
//  State priority, evaluated each cycle: FAULT > BRAKE > RUN/IDLE transitions.
//  IDLE:
//  - Outputs: drv_mag=0, brake_n=1.
//  - brake_req => BRAKE; else en => RUN.
//  RUN:
//  - On tick, drv_mag steps toward tgt by RAMP_STEP, clamped exactly to tgt (no overshoot).
//  - tgt = en ? target_mag : 0. A target_mag change mid-ramp retargets immediately.
//  - en==0 and drv_mag==0 => IDLE.
//  - brake_req => BRAKE.
//  - Stall: drv_mag>=STALL_MIN_MAG and pcnt>=STALL_CYC => FAULT.
//  BRAKE:
//  - Outputs: drv_mag=0, brake_n=0; hold counter starts at 0 on entry.
//  - Exit to IDLE when hold count>=BRAKE_HOLD and brake_req==0.
//  - Magnitude is not ramped; a brake is an immediate stop.
//  FAULT:
//  - Outputs: drv_mag=0, brake_n=0, fault=1.
//  - Exit to IDLE only when clr_fault==1 and en==0. brake_req is ignored.
//  - pcnt is reset to 0 on FAULT exit so the stall check does not re-fire at once.
//  Output timing: all outputs are registered and change the cycle after the state change.
//  Width rules: drv_mag arithmetic is done in 13 bits, then clamped to the range [0, 4095].
// TESTING
//  1. Soft start: en=1, target=12'h400, RAMP_DIV=4, STEP=4, halls rotating -> drv_mag +4 every 4 cycles, reaches 0x400 exactly, running=1.
//  2. Retarget/stop: in RUN at 0x400, set target=0x3FE -> clamps to 0x3FE; drop en -> ramps to 0, IDLE, comm_period=FFFFFF.
//  3. Period: hall step every 1000 cycles in RUN -> comm_period==1000 after second transition; codes 000/111 not counted.
//  4. Stall: drv_mag=0x200, halls frozen -> fault=1, brake_n=0, drv_mag=0 at STALL_CYC (+1 reg); clr_fault with en=1 ignored, with en=0 -> IDLE.
//  5. Brake: brake_req pulse 5 cycles in RUN -> brake_n=0 for exactly BRAKE_HOLD(+1) cycles, drv_mag=0, then IDLE; brake_req and stall in same cycle -> FAULT.
//  6. Reset mid-RUN at drv_mag=0x300 -> next edge all outputs at reset values; 15 cycles of hall=111 no fault, 16 -> FAULT.

Source files
------------

// File: rtl/motor_drive_sequencer.sv
// motor_drive_sequencer
//   Drives the brushless commutation stage. The drive magnitude is slewed
//   toward the requested torque magnitude (soft start/stop), a brake request
//   forces an immediate stop, and a stall or a persistent invalid hall code
//   latches a fault that holds the motor braked until cleared. The time
//   between hall transitions is measured for the speed loop.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   en              run request; when dropped the drive ramps to 0 then idles
//   brake_req       level brake request
//   clr_fault       fault clear, honoured only while en is low
//   target_mag      requested drive magnitude (12 bit)
//   hallGrn/Ylw/Blu asynchronous hall sensor inputs
//   drv_mag         slewed magnitude to the commutation block (registered)
//   brake_n         active-low brake to the commutation block (registered)
//   running         high while in RUN (registered)
//   fault           high while in FAULT (registered)
//   comm_period     cycles between the last two valid hall transitions,
//                   all-ones when stopped/unknown
module motor_drive_sequencer #(
  parameter int          RAMP_DIV      = 1024,
  parameter int          RAMP_STEP     = 4,
  parameter logic [23:0] STALL_CYC     = 24'd2000000,
  parameter logic [11:0] STALL_MIN_MAG = 12'h100,
  parameter logic [15:0] BRAKE_HOLD    = 16'd50000,
  parameter int          BAD_HALL_CYC  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        brake_req,
  input  logic        clr_fault,
  input  logic [11:0] target_mag,
  input  logic        hallGrn,
  input  logic        hallYlw,
  input  logic        hallBlu,
  output logic [11:0] drv_mag,
  output logic        brake_n,
  output logic        running,
  output logic        fault,
  output logic [23:0] comm_period
);

  localparam int                RAMP_W    = $clog2(RAMP_DIV);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  localparam logic [12:0]       STEP13    = 13'(RAMP_STEP);
  localparam int                BAD_W     = $clog2(BAD_HALL_CYC + 1);
  localparam logic [BAD_W-1:0]  BAD_LIMIT = BAD_W'(BAD_HALL_CYC);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_BRAKE, ST_FAULT} state_t;

  state_t state_reg, state_next;

  logic [2:0]        hall_meta_reg, hall_s, hall_p;
  logic [23:0]       pcnt;
  logic [RAMP_W-1:0] ramp_cnt_reg;
  logic [15:0]       hold_cnt_reg;
  logic [BAD_W-1:0]  bad_cnt_reg;

  logic        hall_bad, hall_edge, tick, stall_hit, bad_hit;
  logic        idle_entry, fault_exit;
  logic [11:0] tgt, mag_step;
  logic [12:0] mag_up, mag_dn;

  assign hall_bad   = (hall_s == 3'b000) || (hall_s == 3'b111);
  assign hall_edge  = (hall_s != hall_p) && !hall_bad;
  assign tick       = (state_reg == ST_RUN) && (ramp_cnt_reg == RAMP_LAST);
  assign stall_hit  = (drv_mag >= STALL_MIN_MAG) && (pcnt >= STALL_CYC);
  assign bad_hit    = (bad_cnt_reg >= BAD_LIMIT);
  assign idle_entry = (state_next == ST_IDLE) && (state_reg != ST_IDLE);
  assign fault_exit = (state_reg == ST_FAULT) && (state_next != ST_FAULT);

  // One ramp step toward the target; the 13-bit sums expose overflow and
  // underflow so the result can be clamped onto the target exactly.
  always_comb begin
    tgt      = en ? target_mag : 12'd0;
    mag_up   = {1'b0, drv_mag} + STEP13;
    mag_dn   = {1'b0, drv_mag} - STEP13;
    mag_step = drv_mag;
    if (tgt > drv_mag) begin
      mag_step = (mag_up > {1'b0, tgt}) ? tgt : mag_up[11:0];
    end else if (tgt < drv_mag) begin
      mag_step = (mag_dn[12] || (mag_dn[11:0] < tgt)) ? tgt : mag_dn[11:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Fault outranks brake, which outranks the ordinary run/idle moves.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (brake_req)      state_next = ST_BRAKE;
        else if (en)        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (stall_hit || bad_hit)       state_next = ST_FAULT;
        else if (brake_req)             state_next = ST_BRAKE;
        else if (!en && drv_mag == 12'd0) state_next = ST_IDLE;
      end
      ST_BRAKE: begin
        if ((hold_cnt_reg >= BRAKE_HOLD) && !brake_req) state_next = ST_IDLE;
      end
      ST_FAULT: begin
        if (clr_fault && !en) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hall_meta_reg <= 3'b000;
      hall_s        <= 3'b000;
      hall_p        <= 3'b000;
      pcnt          <= 24'd0;
      comm_period   <= 24'hFFFFFF;
      ramp_cnt_reg  <= '0;
      hold_cnt_reg  <= 16'd0;
      bad_cnt_reg   <= '0;
      drv_mag       <= 12'd0;
      brake_n       <= 1'b1;
      running       <= 1'b0;
      fault         <= 1'b0;
    end else begin
      hall_meta_reg <= {hallGrn, hallYlw, hallBlu};
      hall_s        <= hall_meta_reg;
      hall_p        <= hall_s;

      if (!hall_bad)                  bad_cnt_reg <= '0;
      else if (bad_cnt_reg != BAD_LIMIT) bad_cnt_reg <= bad_cnt_reg + BAD_W'(1);

      // Period is only measured while running; elsewhere the counter just
      // saturates. Leaving FAULT restarts it so the stall check is not
      // satisfied again immediately.
      if (fault_exit)                           pcnt <= 24'd0;
      else if (state_reg == ST_RUN && hall_edge) pcnt <= 24'd1;
      else if (pcnt != 24'hFFFFFF)              pcnt <= pcnt + 24'd1;

      if (idle_entry)                            comm_period <= 24'hFFFFFF;
      else if (state_reg == ST_RUN && hall_edge) comm_period <= pcnt;

      if (state_reg != ST_RUN || tick) ramp_cnt_reg <= '0;
      else                             ramp_cnt_reg <= ramp_cnt_reg + RAMP_W'(1);

      if (state_reg != ST_BRAKE)         hold_cnt_reg <= 16'd0;
      else if (hold_cnt_reg != 16'hFFFF) hold_cnt_reg <= hold_cnt_reg + 16'd1;

      if (state_reg != ST_RUN) drv_mag <= 12'd0;
      else if (tick)           drv_mag <= mag_step;

      brake_n <= !((state_reg == ST_BRAKE) || (state_reg == ST_FAULT));
      running <= (state_reg == ST_RUN);
      fault   <= (state_reg == ST_FAULT);
    end
  end

endmodule
